// File: rtl/wb_pkg.sv
// Shared widths, constants and types for the write-back controller.
package wb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] RF_ADDR_ZERO = '0;

    typedef logic [0:0] wb_state_t;
    localparam wb_state_t NORMAL = 1'b0;
    localparam wb_state_t DRAIN  = 1'b1;

    typedef enum logic {
        PIPE = 1'b0,
        MD   = 1'b1
    } wb_src_t;

endpackage

// File: rtl/wb_queue.sv
// Small FIFO of pending mul/div results; exposes per-entry address/valid for hazard queries.
module wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [ADDR_W-1:0]            head_addr,
    output logic [DATA_W-1:0]            head_data,
    output logic                         full,
    output logic                         empty,
    output logic [DEPTH-1:0]             entry_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0] entry_addr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic [CNT_W-1:0]             count;
    logic [DEPTH-1:0]             valid;
    logic [DEPTH-1:0][ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]            mem_data [DEPTH];
    logic                         do_push;
    logic                         do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_addr   = mem_addr[rd_ptr];
    assign head_data   = mem_data[rd_ptr];
    assign entry_valid = valid;
    assign entry_addr  = mem_addr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr        <= wr_ptr + 1'b1;
                valid[wr_ptr] <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr        <= rd_ptr + 1'b1;
                valid[rd_ptr] <= 1'b0;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_data[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/wb_ctrl.sv
// Write-back arbiter: W-stage results have priority, queued mul/div results fill idle slots,
// and a starvation drain stalls the pipe for one cycle. Optional trace: WB_CTRL_TRACE_EN.
module wb_ctrl
    import wb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_valid,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_data,
    output logic              pipe_stall,
    input  logic              md_valid,
    input  logic [ADDR_W-1:0] md_addr,
    input  logic [DATA_W-1:0] md_data,
    output logic              md_ready,
    input  logic [ADDR_W-1:0] query_addr1,
    input  logic [ADDR_W-1:0] query_addr2,
    output logic              query_pending1,
    output logic              query_pending2,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data
);

    localparam logic [3:0] STARVE_CNT_LIMIT = 4'(STARVE_LIMIT);

    wb_state_t                    state;
    wb_state_t                    state_next;
    logic [3:0]                   starve_cnt;
    logic [3:0]                   starve_next;
    logic                         q_push;
    logic                         q_pop;
    logic                         q_full;
    logic                         q_empty;
    logic [ADDR_W-1:0]            head_addr;
    logic [DATA_W-1:0]            head_data;
    logic [DEPTH-1:0]             entry_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] entry_addr;
    logic                         pipe_take;
    logic                         starved;
    logic                         hit1;
    logic                         hit2;

    wb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (q_push),
        .push_addr   (md_addr),
        .push_data   (md_data),
        .pop         (q_pop),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .full        (q_full),
        .empty       (q_empty),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    // Handshakes: an md result transfers on md_valid && md_ready, and md_ready depends only on
    // queue fullness (never on md_valid or a same-cycle pop); pipe_stall high means the W stage
    // must present the same result again next cycle, otherwise a pipe_valid result is consumed.
    assign md_ready   = !q_full;
    assign q_push     = md_valid && !q_full && (md_addr != RF_ADDR_ZERO);
    assign pipe_stall = (state == DRAIN) && pipe_valid;
    assign pipe_take  = (state == NORMAL) && pipe_valid && (pipe_addr != RF_ADDR_ZERO);
    assign q_pop      = !q_empty && ((state == DRAIN) || !pipe_take);
    assign starved    = (state == NORMAL) && !q_empty && !q_pop;

    always_comb begin
        state_next  = state;
        starve_next = '0;
        if (state == DRAIN) begin
            state_next = NORMAL;
        end else if (starved) begin
            starve_next = starve_cnt + 4'd1;
            if (starve_next == STARVE_CNT_LIMIT) begin
                state_next = DRAIN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= NORMAL;
            starve_cnt   <= '0;
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
        end else begin
            state        <= state_next;
            starve_cnt   <= starve_next;
            write_enable <= pipe_take || q_pop;
            if (pipe_take) begin
                write_addr <= pipe_addr;
                write_data <= pipe_data;
            end else if (q_pop) begin
                write_addr <= head_addr;
                write_data <= head_data;
            end
        end
    end

    // A register is pending while any queued entry or the in-flight write targets it.
    always_comb begin
        hit1 = write_enable && (write_addr == query_addr1);
        hit2 = write_enable && (write_addr == query_addr2);
        for (int i = 0; i < DEPTH; i++) begin
            hit1 = hit1 || (entry_valid[i] && (entry_addr[i] == query_addr1));
            hit2 = hit2 || (entry_valid[i] && (entry_addr[i] == query_addr2));
        end
    end

    assign query_pending1 = (query_addr1 != RF_ADDR_ZERO) && hit1;
    assign query_pending2 = (query_addr2 != RF_ADDR_ZERO) && hit2;

`ifdef WB_CTRL_TRACE_EN
    wb_src_t trace_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_src <= PIPE;
        end else if (pipe_take) begin
            trace_src <= PIPE;
        end else if (q_pop) begin
            trace_src <= MD;
        end
    end

    // Reports the write the register file commits on this edge.
    always @(posedge clk) begin
        if (rst_n && write_enable) begin
            $display("wb: $%0d <= 0x%08h (%s)", write_addr, write_data,
                     (trace_src == PIPE) ? "pipe" : "md");
        end
    end
`endif

endmodule

// File: tb/tb_wb_ctrl.sv
// Self-checking bench for wb_ctrl: directed scenarios plus randomized traffic against a queue-level model.
module tb_wb_ctrl;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_valid = 1'b0;
    logic [4:0]  pipe_addr = '0;
    logic [31:0] pipe_data = '0;
    logic        pipe_stall;
    logic        md_valid = 1'b0;
    logic [4:0]  md_addr = '0;
    logic [31:0] md_data = '0;
    logic        md_ready;
    logic [4:0]  query_addr1 = '0;
    logic [4:0]  query_addr2 = '0;
    logic        query_pending1;
    logic        query_pending2;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;

    int errors = 0;
    int checks = 0;

    // Model state: pending mul/div results {addr, data}, drain flag, starved-cycle count.
    logic [36:0] exp_q[$];
    logic        drain_m = 1'b0;
    int          starve_m = 0;
    logic [37:0] exp_wr = '0;
    logic [37:0] act_wr;
    logic [3:0]  exp_comb;
    logic [3:0]  act_comb;

    wb_ctrl #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pipe_valid     (pipe_valid),
        .pipe_addr      (pipe_addr),
        .pipe_data      (pipe_data),
        .pipe_stall     (pipe_stall),
        .md_valid       (md_valid),
        .md_addr        (md_addr),
        .md_data        (md_data),
        .md_ready       (md_ready),
        .query_addr1    (query_addr1),
        .query_addr2    (query_addr2),
        .query_pending1 (query_pending1),
        .query_pending2 (query_pending2),
        .write_enable   (write_enable),
        .write_addr     (write_addr),
        .write_data     (write_data)
    );

    always #5 clk = ~clk;

    function automatic logic model_pending(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (exp_wr[37] && exp_wr[36:32] == a) return 1'b1;
        foreach (exp_q[i]) begin
            if (exp_q[i][36:32] == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_step();
        logic        had;
        logic        popped;
        logic        ready;
        logic [37:0] nw;
        had    = (exp_q.size() != 0);
        popped = 1'b0;
        ready  = (exp_q.size() < DEPTH);
        nw     = {1'b0, exp_wr[36:0]};
        if (drain_m) begin
            if (had) begin
                nw = {1'b1, exp_q.pop_front()};
                popped = 1'b1;
            end
        end else if (pipe_valid && pipe_addr != 5'd0) begin
            nw = {1'b1, pipe_addr, pipe_data};
        end else if (had) begin
            nw = {1'b1, exp_q.pop_front()};
            popped = 1'b1;
        end
        if (drain_m) begin
            drain_m  = 1'b0;
            starve_m = 0;
        end else if (had && !popped) begin
            starve_m++;
            if (starve_m == STARVE_LIMIT) drain_m = 1'b1;
        end else begin
            starve_m = 0;
        end
        if (md_valid && ready && md_addr != 5'd0) exp_q.push_back({md_addr, md_data});
        exp_wr = nw;
    endtask

    // One clock cycle: drive, sample combinational outputs mid-cycle, step model, sample flops after the edge.
    task automatic cycle(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] mdat,
                         input logic [4:0] q1, input logic [4:0] q2);
        pipe_valid  = pv;
        pipe_addr   = pa;
        pipe_data   = pd;
        md_valid    = mv;
        md_addr     = ma;
        md_data     = mdat;
        query_addr1 = q1;
        query_addr2 = q2;
        #1;
        exp_comb = {drain_m && pipe_valid, exp_q.size() < DEPTH,
                    model_pending(query_addr1), model_pending(query_addr2)};
        act_comb = {pipe_stall, md_ready, query_pending1, query_pending2};
        model_step();
        @(posedge clk);
        #1;
        act_wr = {write_enable, write_addr, write_data};
    endtask

    task automatic idle(input logic [4:0] q1);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, q1, 5'd0);
    endtask

    task automatic assert_reset();
        rst_n       = 1'b0;
        pipe_valid  = 1'b0;
        md_valid    = 1'b0;
        query_addr1 = '0;
        query_addr2 = '0;
        exp_q.delete();
        drain_m  = 1'b0;
        starve_m = 0;
        exp_wr   = '0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        assert_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({write_enable, write_addr, write_data} !== 38'd0)
            begin errors++; $display("FAIL reset_write: got %h expected 0", {write_enable, write_addr, write_data}); end
        checks++;
        if ({pipe_stall, md_ready} !== 2'b01)
            begin errors++; $display("FAIL reset_handshake: got stall/ready %b expected 01", {pipe_stall, md_ready}); end
        release_reset();
    endtask

    task automatic test_md_write();
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 5'd5, 5'd0);
        checks++;
        if (act_wr[37] !== 1'b0)
            begin errors++; $display("FAIL md_no_bypass: got we %b expected 0", act_wr[37]); end
        idle(5'd5);
        checks++;
        if (act_comb[1] !== 1'b1)
            begin errors++; $display("FAIL md_pending_queued: got %b expected 1", act_comb[1]); end
        checks++;
        if (act_wr !== {1'b1, 5'd5, 32'h0000_1234})
            begin errors++; $display("FAIL md_write: got %h expected %h", act_wr, {1'b1, 5'd5, 32'h0000_1234}); end
        idle(5'd5);
        checks++;
        if (act_comb[1] !== 1'b1)
            begin errors++; $display("FAIL md_pending_write: got %b expected 1", act_comb[1]); end
        checks++;
        if (act_wr[37] !== 1'b0)
            begin errors++; $display("FAIL md_write_pulse: got we %b expected 0", act_wr[37]); end
        idle(5'd5);
        checks++;
        if (act_comb[1] !== 1'b0)
            begin errors++; $display("FAIL md_pending_clear: got %b expected 0", act_comb[1]); end
    endtask

    task automatic test_same_cycle();
        cycle(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 5'd3, 5'd4);
        checks++;
        if (act_wr !== {1'b1, 5'd3, 32'hA})
            begin errors++; $display("FAIL same_pipe_first: got %h expected %h", act_wr, {1'b1, 5'd3, 32'hA}); end
        idle(5'd4);
        checks++;
        if (act_wr !== {1'b1, 5'd4, 32'hB})
            begin errors++; $display("FAIL same_md_second: got %h expected %h", act_wr, {1'b1, 5'd4, 32'hB}); end
        idle(5'd0);
        checks++;
        if (act_wr[37] !== 1'b0)
            begin errors++; $display("FAIL same_idle: got we %b expected 0", act_wr[37]); end
    endtask

    task automatic test_starve();
        cycle(1'b1, 5'd10, 32'h100, 1'b1, 5'd6, 32'h60, 5'd0, 5'd0);
        cycle(1'b1, 5'd10, 32'h101, 1'b1, 5'd7, 32'h70, 5'd0, 5'd0);
        cycle(1'b1, 5'd10, 32'h102, 1'b1, 5'd8, 32'h80, 5'd0, 5'd0);
        checks++;
        if (act_comb[2] !== 1'b0)
            begin errors++; $display("FAIL starve_full_ready: got %b expected 0", act_comb[2]); end
        cycle(1'b1, 5'd10, 32'h103, 1'b1, 5'd8, 32'h80, 5'd0, 5'd0);
        cycle(1'b1, 5'd10, 32'h104, 1'b1, 5'd8, 32'h80, 5'd0, 5'd0);
        checks++;
        if (act_comb[3] !== 1'b0 || act_wr !== {1'b1, 5'd10, 32'h104})
            begin errors++; $display("FAIL starve_before_drain: got stall %b wr %h expected 0 %h", act_comb[3], act_wr, {1'b1, 5'd10, 32'h104}); end
        cycle(1'b1, 5'd10, 32'h105, 1'b1, 5'd8, 32'h80, 5'd0, 5'd0);
        checks++;
        if (act_comb[3:2] !== 2'b10)
            begin errors++; $display("FAIL drain_stall_ready: got %b expected 10", act_comb[3:2]); end
        checks++;
        if (act_wr !== {1'b1, 5'd6, 32'h60})
            begin errors++; $display("FAIL drain_write: got %h expected %h", act_wr, {1'b1, 5'd6, 32'h60}); end
        cycle(1'b1, 5'd10, 32'h105, 1'b1, 5'd8, 32'h80, 5'd0, 5'd0);
        checks++;
        if (act_comb[3:2] !== 2'b01 || act_wr !== {1'b1, 5'd10, 32'h105})
            begin errors++; $display("FAIL after_drain: got %b %h expected 01 %h", act_comb[3:2], act_wr, {1'b1, 5'd10, 32'h105}); end
        idle(5'd0);
        checks++;
        if (act_wr !== {1'b1, 5'd7, 32'h70})
            begin errors++; $display("FAIL fifo_first: got %h expected %h", act_wr, {1'b1, 5'd7, 32'h70}); end
        idle(5'd0);
        checks++;
        if (act_wr !== {1'b1, 5'd8, 32'h80})
            begin errors++; $display("FAIL fifo_second: got %h expected %h", act_wr, {1'b1, 5'd8, 32'h80}); end
        idle(5'd0);
    endtask

    task automatic test_zero_addr();
        cycle(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 5'd0, 5'd0);
        checks++;
        if (act_comb !== 4'b0100 || act_wr[37] !== 1'b0)
            begin errors++; $display("FAIL zero_first: got comb %b we %b expected 0100 0", act_comb, act_wr[37]); end
        idle(5'd0);
        checks++;
        if (act_wr[37] !== 1'b0 || act_comb[1:0] !== 2'b00)
            begin errors++; $display("FAIL zero_discard: got we %b pend %b expected 0 00", act_wr[37], act_comb[1:0]); end
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 5'd9, 5'd0);
        cycle(1'b1, 5'd0, 32'h5, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
        checks++;
        if (act_comb[3] !== 1'b0 || act_wr !== {1'b1, 5'd9, 32'h99})
            begin errors++; $display("FAIL zero_pipe_pop: got stall %b wr %h expected 0 %h", act_comb[3], act_wr, {1'b1, 5'd9, 32'h99}); end
        idle(5'd0);
    endtask

    task automatic test_mid_reset();
        cycle(1'b1, 5'd1, 32'h11, 1'b1, 5'd12, 32'hC, 5'd0, 5'd0);
        cycle(1'b1, 5'd2, 32'h22, 1'b1, 5'd13, 32'hD, 5'd0, 5'd0);
        assert_reset();
        query_addr1 = 5'd12;
        query_addr2 = 5'd13;
        #1;
        checks++;
        if ({write_enable, write_addr, write_data} !== 38'd0)
            begin errors++; $display("FAIL mid_reset_outputs: got %h expected 0", {write_enable, write_addr, write_data}); end
        checks++;
        if ({pipe_stall, md_ready, query_pending1, query_pending2} !== 4'b0100)
            begin errors++; $display("FAIL mid_reset_queue: got %b expected 0100", {pipe_stall, md_ready, query_pending1, query_pending2}); end
        release_reset();
        for (int i = 0; i < 3; i++) begin
            idle(5'd12);
            checks++;
            if (act_wr[37] !== 1'b0 || act_comb[1] !== 1'b0)
                begin errors++; $display("FAIL mid_reset_no_write: cycle %0d got we %b pend %b expected 0 0", i, act_wr[37], act_comb[1]); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            checks++;
            if (act_comb !== exp_comb)
                begin errors++; $display("FAIL rand_comb: cycle %0d got %b expected %b", n, act_comb, exp_comb); end
            checks++;
            if (act_wr[37] !== exp_wr[37] || (exp_wr[37] && act_wr !== exp_wr))
                begin errors++; $display("FAIL rand_write: cycle %0d got %h expected %h", n, act_wr, exp_wr); end
        end
    endtask

    initial begin
        test_reset();
        test_md_write();
        test_same_cycle();
        test_starve();
        test_zero_addr();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_ctrl.md
WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 Parameter: DEPTH, default 2; number of entries in the mul/div result queue (power of two, 2..8).
REQ-002 Parameter: STARVE_LIMIT, default 4; consecutive cycles the queue may wait before a forced drain (1..15).
REQ-003 Ports, in order (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pipe_valid  in  1  W-stage result present.
- pipe_addr  in  5  W-stage destination register.
- pipe_data  in  32  W-stage result.
- pipe_stall  out  1  W-stage must hold its result this cycle.
- md_valid  in  1  mul/div result offered.
- md_addr  in  5  mul/div destination register.
- md_data  in  32  mul/div result.
- md_ready  out  1  queue accepts the offered result.
- query_addr1  in  5  first register-file read address to check.
- query_addr2  in  5  second register-file read address to check.
- query_pending1  out  1  query_addr1 has an uncommitted write.
- query_pending2  out  1  query_addr2 has an uncommitted write.
- write_enable  out  1  drives the register-file write port; registered.
- write_addr  out  5  drives the register-file write port; registered.
- write_data  out  32  drives the register-file write port; registered.

Function
REQ-004 The block shall launch at most one register-file write per cycle, and all write outputs shall come from flops.
REQ-005 md_ready shall equal NOT full; an md transfer occurs when md_valid and md_ready are both high, and the result is pushed at the queue tail.
REQ-006 An md transfer with md_addr == 0 shall be accepted and discarded without being pushed.
REQ-007 There shall be two states, NORMAL and DRAIN.
REQ-008 NORMAL: a valid pipe write with nonzero address shall be latched to the outputs at the next edge; otherwise a nonempty queue shall pop its head to the outputs; otherwise write_enable shall go to 0 at the next edge.
REQ-009 A pipe write with pipe_addr == 0 shall be consumed, shall not stall, and shall leave the edge free for a queue pop.
REQ-010 Starvation counter: increments in each NORMAL cycle in which the queue is nonempty and not popped; clears on every pop or when the queue is empty.
REQ-011 Transition NORMAL->DRAIN shall occur when the counter reaches STARVE_LIMIT.
REQ-012 DRAIN: pipe_stall = pipe_valid; the queue head is popped; the state returns to NORMAL with the counter cleared after exactly one cycle.
REQ-013 pipe_stall shall be 0 in NORMAL.
REQ-014 There shall be no push-to-pop bypass: the earliest write of an md result is 2 edges after acceptance.
REQ-015 When full, md_ready is low even if a pop occurs in the same cycle.
REQ-016 query_pendingN shall be combinational and equal 1 iff queryN is nonzero and matches a valid queue entry or (write_enable and write_addr).
REQ-017 Duplicate queue addresses are legal; entries shall commit in FIFO order.

Reset
REQ-018 When rst_n is low, write_enable = 0, write_addr = 0, write_data = 0, the queue is empty, the counter is 0 and the state is NORMAL; pipe_stall = 0 and md_ready = 1 while reset is held.
REQ-019 Reset asserted mid-operation shall discard queued results without issuing a partial write.

Configuration
REQ-020 Macro WB_CTRL_TRACE_EN, when defined, shall add simulation-only output of one line per committed write, "wb: $<addr> <= 0x<data8hex> (<pipe|md>)".
REQ-021 When WB_CTRL_TRACE_EN is not defined, no trace code shall be elaborated and function shall be identical.

Structure
REQ-022 Package wb_pkg shall hold: the RF_ADDR_ZERO constant, the address and data width constants, the NORMAL/DRAIN state type, and the source tag type (PIPE/MD).
REQ-023 The queue shall be a sub-module, wb_queue, exposing push, pop, head, full, empty and per-entry valid/address vectors for the query match.

Verification
REQ-024 md write ($5, 0x1234) with no pipe traffic: write_enable at edge 2 with addr 5, data 0x00001234; query_pending for 5 high from acceptance until the cycle after the write.
REQ-025 pipe write ($3, 0xA) and md push ($4, 0xB) in the same cycle: $3 written at edge 1, $4 written at edge 2.
REQ-026 DEPTH = 2, three back-to-back md offers with continuous pipe traffic: md_ready low on the third offer; after 4 starved cycles pipe_stall = 1 for one cycle and the head is written.
REQ-027 Pipe write to $0 and md write to $0: no write_enable pulse, and query_pending stays 0.
REQ-028 rst_n pulsed low with 2 entries queued: outputs go to zero immediately, the queue is empty, and no write occurs after release.
